// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared types and width helpers for the adder-tree frame controller
package adder_tree_pkg;

    function automatic int tree_width(input int n, input int dw);
        return dw + $clog2(n);
    endfunction

    typedef struct packed {
        logic valid;
        logic last;
    } tree_tag_t;

    typedef enum logic {IDLE, OPEN} frame_state_e;

endpackage

// File: rtl/adder_tree_frame_ctrl_tag_pipe.sv
// adder_tree_frame_ctrl_tag_pipe: LAT-deep tag shift register that tracks beats travelling through the tree
// Ports: clock, reset_n (async, active-low), ena (advance), clr (sync clear), din (tag into stage 0), dout (tail tag)
module adder_tree_frame_ctrl_tag_pipe
    import adder_tree_pkg::*;
#(
    parameter int LAT = 5
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      ena,
    input  logic      clr,
    input  tree_tag_t din,
    output tree_tag_t dout
);

    tree_tag_t [LAT-1:0] stages;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else if (clr) begin
            stages <= '0;
        end else if (ena) begin
            stages[0] <= din;
            for (int i = 1; i < LAT; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[LAT-1];

endmodule

// File: rtl/adder_tree_frame_ctrl.sv
// adder_tree_frame_ctrl: feeds a pipelined adder tree and accumulates its outputs into one sum per frame
// Ports: clock, reset_n; beat input in_valid/in_ready/in_data/in_last; abort;
//        tree side tree_data/tree_ena/tree_result; result out_valid/out_ready/out_data/out_beats/out_ovf
module adder_tree_frame_ctrl
    import adder_tree_pkg::*;
#(
    parameter  int N          = 32,
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_BEATS  = 16,
    localparam int LAT        = $clog2(N),
    localparam int TREE_WIDTH = tree_width(N, DATA_WIDTH),
    localparam int ACC_WIDTH  = TREE_WIDTH + $clog2(MAX_BEATS),
    localparam int CNT_WIDTH  = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    input  logic                    in_last,
    input  logic                    abort,
    output logic [N*DATA_WIDTH-1:0] tree_data,
    output logic                    tree_ena,
    input  logic [TREE_WIDTH-1:0]   tree_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_WIDTH-1:0]    out_data,
    output logic [CNT_WIDTH-1:0]    out_beats,
    output logic                    out_ovf
);

    tree_tag_t            tail;
    frame_state_e         state;
    logic [ACC_WIDTH-1:0] acc, acc_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic                 ovf, ovf_next, stall, accept, fire, sat;

    // A blocked result freezes the tree and the tags together, so no tail is consumed until it drains.
    assign stall     = out_valid && !out_ready;
    assign tree_ena  = !stall;
    assign in_ready  = !stall && !abort;
    assign accept    = in_valid && in_ready;
    assign tree_data = in_data;

    // Abort discards whatever tail is arriving this cycle along with the rest of the pipeline.
    assign fire     = tree_ena && tail.valid && !abort;
    assign acc_next = acc + {{(ACC_WIDTH-TREE_WIDTH){tree_result[TREE_WIDTH-1]}}, tree_result};
    assign sat      = cnt == CNT_WIDTH'(MAX_BEATS);
    assign cnt_next = sat ? cnt : cnt + 1'b1;
    assign ovf_next = ovf || sat;

    adder_tree_frame_ctrl_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .ena     (tree_ena),
        .clr     (abort),
        .din     (tree_tag_t'{valid: accept, last: in_last}),
        .dout    (tail)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
            state     <= IDLE;
        end else begin
            if (abort) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (fire) begin
                acc <= tail.last ? '0 : acc_next;
                cnt <= tail.last ? '0 : cnt_next;
                ovf <= tail.last ? 1'b0 : ovf_next;
            end
            if (fire && tail.last) begin
                out_valid <= 1'b1;
                out_data  <= acc_next;
                out_beats <= cnt_next;
                out_ovf   <= ovf_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            state <= abort ? IDLE : accept ? (in_last ? IDLE : OPEN) : state;
        end
    end

endmodule

// File: tb/tb_adder_tree_frame_ctrl.sv
// tb_adder_tree_frame_ctrl: scoreboard bench with a behavioural adder tree and frame-level reference model
module tb_adder_tree_frame_ctrl;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int LAT = 2;
    localparam int TW  = DW + 2;
    localparam int AW  = TW + 2;
    localparam int CW  = 3;

    typedef struct packed {
        logic [AW-1:0] data;
        logic [CW-1:0] beats;
        logic          ovf;
    } exp_t;

    logic          clock = 0, reset_n = 0;
    logic          in_valid = 0, in_last = 0, abort = 0, out_ready = 1;
    logic [N*DW-1:0] in_data = '0;
    logic          in_ready, tree_ena, out_valid, out_ovf;
    logic [N*DW-1:0] tree_data;
    logic [TW-1:0] tree_result;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_beats;

    int     checks = 0, failures = 0;
    exp_t   q[$];
    longint fr_sum = 0;
    int     fr_beats = 0;
    logic   rand_rdy = 0;

    always #5 clock = ~clock;

    adder_tree_frame_ctrl #(.N(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .abort       (abort),
        .tree_data   (tree_data),
        .tree_ena    (tree_ena),
        .tree_result (tree_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_beats   (out_beats),
        .out_ovf     (out_ovf)
    );

    function automatic longint lane_sum(input logic [N*DW-1:0] d);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'($signed(d[i*DW +: DW]));
        return s;
    endfunction

    // Behavioural stand-in for the pipelined tree: LAT registered stages sharing clock_ena.
    logic [TW-1:0] tpipe [LAT];
    always @(posedge clock) begin
        if (tree_ena) begin
            tpipe[0] <= TW'(lane_sum(tree_data));
            for (int i = 1; i < LAT; i++) tpipe[i] <= tpipe[i-1];
        end
    end
    assign tree_result = tpipe[LAT-1];

    always @(negedge clock) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

    // Monitor: just before each rising edge, a handshake pops the next expected frame.
    always @(negedge clock) begin
        exp_t e;
        #4;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL out_frame unexpected result data=%0d beats=%0d ovf=%0d", $signed(out_data), out_beats, out_ovf);
            end else begin
                e = q.pop_front();
                if (out_data !== e.data || out_beats !== e.beats || out_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL out_frame got data=%0d beats=%0d ovf=%0d expected data=%0d beats=%0d ovf=%0d",
                             $signed(out_data), out_beats, out_ovf, $signed(e.data), e.beats, e.ovf);
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] lanes(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    // Called at a falling edge; returns at the falling edge after the beat is accepted.
    task automatic send(input logic [N*DW-1:0] d, input logic last);
        int   b = 0;
        logic ok;
        in_valid = 1;
        in_data  = d;
        in_last  = last;
        do begin
            #1;
            ok = in_ready;
            @(negedge clock);
            b++;
        end while (!ok && b < 200);
        in_valid = 0;
        in_last  = 0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=in_ready_low expected=accept");
        end else begin
            fr_sum += lane_sum(d);
            fr_beats++;
            if (last) begin
                q.push_back(exp_t'{AW'(fr_sum), CW'(fr_beats > MB ? MB : fr_beats), fr_beats > MB});
                fr_sum   = 0;
                fr_beats = 0;
            end
        end
    endtask

    task automatic do_abort();
        abort    = 1;
        in_valid = 1;
        in_last  = 1;
        in_data  = lanes(9, 9, 9, 9);
        #1;
        chk("abort_in_ready", longint'(in_ready), 0);
        @(negedge clock);
        abort    = 0;
        in_valid = 0;
        in_last  = 0;
        fr_sum   = 0;
        fr_beats = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d pending expected=0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clock);
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_out_beats", longint'(out_beats), 0);
        chk("reset_out_ovf", longint'(out_ovf), 0);
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);

        // single beat and latency
        send(lanes(1, 2, 3, 4), 1);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!out_valid && n < 10);
        chk("t1_latency", n, LAT);
        @(negedge clock);
        drain();

        // three beats of the most negative lane value
        for (int i = 0; i < 3; i++) send(lanes(-128, -128, -128, -128), i == 2);
        drain();

        // back-to-back frames with the first result held off for five cycles
        send(lanes(1, 1, 1, 1), 1);
        send(lanes(2, 2, 2, 2), 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_stall_in_ready", longint'(in_ready), 0);
            chk("t3_stall_tree_ena", longint'(tree_ena), 0);
            chk("t3_stall_out_data", longint'($signed(out_data)), 4);
            @(negedge clock);
        end
        out_ready = 1;
        drain();

        // abort an open frame, then a single-beat frame
        send(lanes(1, 1, 1, 1), 0);
        send(lanes(1, 1, 1, 1), 0);
        do_abort();
        send(lanes(5, 5, 5, 5), 1);
        drain();

        // abort right after a complete frame is still inside the pipeline
        send(lanes(3, 3, 3, 3), 1);
        do_abort();
        void'(q.pop_back());
        repeat (4) @(negedge clock);
        #1;
        chk("t4_inflight_discard", longint'(out_valid), 0);
        @(negedge clock);

        // beat-count saturation, then a normal frame to show the flag clears
        for (int i = 0; i < 6; i++) send(lanes(1, 0, 0, 0), i == 5);
        send(lanes(2, 0, 0, 0), 1);
        drain();

        // reset with an open frame and a held result
        send(lanes(1, 1, 1, 1), 0);
        send(lanes(1, 1, 1, 1), 0);
        out_ready = 0;
        send(lanes(9, 9, 9, 9), 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        reset_n = 0;
        void'(q.pop_back());
        fr_sum   = 0;
        fr_beats = 0;
        #1;
        chk("t6_reset_out_valid", longint'(out_valid), 0);
        chk("t6_reset_out_data", longint'(out_data), 0);
        repeat (2) @(negedge clock);
        reset_n   = 1;
        out_ready = 1;
        @(negedge clock);
        send(lanes(7, 0, 0, 0), 1);
        drain();

        // randomized frames with random backpressure, gaps and aborts
        rand_rdy = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            if ($urandom_range(0, 5) == 0) begin
                drain();
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) send(N*DW'($urandom), 0);
                do_abort();
            end
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                send(N*DW'($urandom), b == len - 1);
                repeat ($urandom_range(0, 1)) @(negedge clock);
            end
        end
        drain();
        rand_rdy = 0;
        @(negedge clock);
        out_ready = 1;
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
